// File: rtl/tsconf_audio_mix_if.sv
// Sample-stream bundle between the tsconf sound source and the stereo mixer.
// master: drives the strobe, the mix setting and the input samples, and receives the mixed samples.
// slave : the mixer side, which takes the inputs and drives out_l/out_r, out_valid and clip.
interface tsconf_audio_mix_if #(
  parameter int unsigned DW = 16
);
  logic                 ce_smp;
  logic [1:0]           mix;
  logic signed [DW-1:0] in_l;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] out_l;
  logic signed [DW-1:0] out_r;
  logic                 out_valid;
  logic                 clip;

  modport master (
    output ce_smp, mix, in_l, in_r,
    input  out_l, out_r, out_valid, clip
  );

  modport slave (
    input  ce_smp, mix, in_l, in_r,
    output out_l, out_r, out_valid, clip
  );
endinterface

// File: rtl/tsconf_audio_mix.sv
// Stereo crossfeed mixer placed between the tsconf SOUND_L/SOUND_R outputs and the sigma-delta DACs.
// The crossfeed weight (in eighths) follows the OSD "Stereo mix" setting and ramps one step per
// sample, so that a change of setting does not click. The datapath is fully pipelined and has no
// backpressure.
//
// Ports:
//   clk_sys        system clock
//   reset          asynchronous, active-high reset
//   bus.ce_smp     sample strobe; a sample is accepted on every edge where it is high
//   bus.mix        stereo-mix setting (status[4:3])
//   bus.in_l/in_r  signed input samples
//   bus.out_l/r    signed mixed samples; they hold their value between valid strobes
//   bus.out_valid  one-cycle strobe per accepted sample
//   bus.clip       saturation flag for the current out_valid sample
//
// Optional feature: define AUDIO_MIX_DCBLOCK_EN to add a first-order DC blocker as stage 4.
// This raises the latency from 3 to 4 and lets clip report saturation in that stage.
// When the macro is not defined, clip is tied to 0.
module tsconf_audio_mix #(
  parameter int unsigned DW   = 16,
  parameter int unsigned WMAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  tsconf_audio_mix_if.slave bus
);

  localparam int unsigned DDW = DW + 1;  // channel difference
  localparam int unsigned PW  = DW + 4;  // weighted difference
  localparam int unsigned SW  = DW + 2;  // stage-3 sum
  localparam int unsigned XW  = DW + 3;  // widest pre-saturation value
  localparam logic [2:0]  W_MAX = 3'(WMAX);

  // Clamp a signed XW-bit value to the DW-bit range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [XW-1:0] v);
    logic signed [DW-1:0] r;
    r = v[DW-1:0];
    if (v[XW-1] && !(&v[XW-2:DW-1])) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else if (!v[XW-1] && (|v[XW-2:DW-1])) begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Weight ramp
  // ---------------------------------------------------------------------------
  logic [2:0] w_cur;
  logic [2:0] w_tgt;
  logic [2:0] w_nxt;

  // Map the mix setting to its target weight.
  always_comb begin
    w_tgt = 3'd0;
    case (bus.mix)
      2'd1:    w_tgt = 3'd1;
      2'd2:    w_tgt = 3'd2;
      2'd3:    w_tgt = W_MAX;
      default: w_tgt = 3'd0;
    endcase
  end

  // Move one step toward the target; the step is applied only when a sample is accepted.
  always_comb begin
    w_nxt = w_cur;
    if (w_cur < w_tgt) begin
      w_nxt = w_cur + 3'd1;
    end else if (w_cur > w_tgt) begin
      w_nxt = w_cur - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: accept the sample, tag it with the current weight, form the channel differences
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic signed [DW-1:0]  s1_l;
  logic signed [DW-1:0]  s1_r;
  logic [2:0]            s1_w;
  logic signed [DDW-1:0] s1_dl;
  logic signed [DDW-1:0] s1_dr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_w     <= '0;
      s1_dl    <= '0;
      s1_dr    <= '0;
      w_cur    <= '0;
    end else begin
      s1_valid <= bus.ce_smp;
      if (bus.ce_smp) begin
        s1_l  <= bus.in_l;
        s1_r  <= bus.in_r;
        s1_w  <= w_cur;
        s1_dl <= DDW'(bus.in_r) - DDW'(bus.in_l);
        s1_dr <= DDW'(bus.in_l) - DDW'(bus.in_r);
        w_cur <= w_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: multiply the differences by the weight with shift-add (w <= 7)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] dl_x;
  logic signed [PW-1:0] dr_x;
  logic signed [PW-1:0] pl_c;
  logic signed [PW-1:0] pr_c;

  always_comb begin
    dl_x = PW'(s1_dl);
    dr_x = PW'(s1_dr);
    pl_c = (s1_w[0] ? dl_x : '0) + (s1_w[1] ? (dl_x <<< 1) : '0) + (s1_w[2] ? (dl_x <<< 2) : '0);
    pr_c = (s1_w[0] ? dr_x : '0) + (s1_w[1] ? (dr_x <<< 1) : '0) + (s1_w[2] ? (dr_x <<< 2) : '0);
  end

  logic                 s2_valid;
  logic signed [DW-1:0] s2_l;
  logic signed [DW-1:0] s2_r;
  logic signed [PW-1:0] s2_pl;
  logic signed [PW-1:0] s2_pr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_l     <= '0;
      s2_r     <= '0;
      s2_pl    <= '0;
      s2_pr    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_l  <= s1_l;
        s2_r  <= s1_r;
        s2_pl <= pl_c;
        s2_pr <= pr_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: add the eighths-scaled crossfeed (>>> 3 rounds toward -inf), then saturate
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sum_l;
  logic signed [SW-1:0] sum_r;
  logic signed [DW-1:0] mix_l;
  logic signed [DW-1:0] mix_r;

  always_comb begin
    sum_l = SW'(s2_l) + SW'(s2_pl >>> 3);
    sum_r = SW'(s2_r) + SW'(s2_pr >>> 3);
    mix_l = sat_dw(XW'(sum_l));
    mix_r = sat_dw(XW'(sum_r));
  end

  logic                 o_valid;
  logic signed [DW-1:0] o_l;
  logic signed [DW-1:0] o_r;

`ifdef AUDIO_MIX_DCBLOCK_EN
  // True when an XW-bit value lies outside the DW-bit range.
  function automatic logic is_sat(input logic signed [XW-1:0] v);
    return !((&v[XW-1:DW-1]) || !(|v[XW-1:DW-1]));
  endfunction

  logic                 s3_valid;
  logic signed [DW-1:0] s3_l;
  logic signed [DW-1:0] s3_r;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_l     <= '0;
      s3_r     <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_l <= mix_l;
        s3_r <= mix_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: DC blocker y = x - x1 + y1 - (y1 >>> 10), one per channel
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] x1_l;
  logic signed [DW-1:0] x1_r;
  logic signed [DW-1:0] y1_l;
  logic signed [DW-1:0] y1_r;
  logic signed [XW-1:0] y_l;
  logic signed [XW-1:0] y_r;
  logic signed [DW-1:0] ys_l;
  logic signed [DW-1:0] ys_r;
  logic                 o_clip;

  always_comb begin
    y_l  = XW'(s3_l) - XW'(x1_l) + XW'(y1_l) - XW'(y1_l >>> 10);
    y_r  = XW'(s3_r) - XW'(x1_r) + XW'(y1_r) - XW'(y1_r >>> 10);
    ys_l = sat_dw(y_l);
    ys_r = sat_dw(y_r);
  end

  // The filter history advances only on valid samples, so gaps in the stream do not disturb it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_l     <= '0;
      o_r     <= '0;
      o_clip  <= 1'b0;
      x1_l    <= '0;
      x1_r    <= '0;
      y1_l    <= '0;
      y1_r    <= '0;
    end else begin
      o_valid <= s3_valid;
      o_clip  <= s3_valid & (is_sat(y_l) | is_sat(y_r));
      if (s3_valid) begin
        o_l  <= ys_l;
        o_r  <= ys_r;
        x1_l <= s3_l;
        x1_r <= s3_r;
        y1_l <= ys_l;
        y1_r <= ys_r;
      end
    end
  end

  assign bus.clip = o_clip;
`else
  // Stage 3 is the output register; out_l/out_r hold between valid samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_l     <= '0;
      o_r     <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_l <= mix_l;
        o_r <= mix_r;
      end
    end
  end

  // With w <= 4 the mixer cannot saturate, and without the DC stage nothing else can.
  assign bus.clip = 1'b0;
`endif

  assign bus.out_valid = o_valid;
  assign bus.out_l     = o_l;
  assign bus.out_r     = o_r;

endmodule

// File: tb/tb_tsconf_audio_mix.sv
// Self-checking bench for tsconf_audio_mix. A behavioural model computes the expected output of each
// accepted sample from integer arithmetic; a queue then releases each result on the edge where it is due.
`timescale 1ns/1ps
module tb_tsconf_audio_mix;
  localparam int unsigned DW   = 16;
  localparam int unsigned WMAX = 4;
`ifdef AUDIO_MIX_DCBLOCK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic clk_sys = 1'b0;
  logic reset;

  tsconf_audio_mix_if #(.DW(DW)) bus ();

  tsconf_audio_mix #(.DW(DW), .WMAX(WMAX)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int due;
    int l;
    int r;
    bit clip;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   m_w;
  int   dc_x1[2];
  int   dc_y1[2];
  bit   exp_valid;
  int   exp_l;
  int   exp_r;
  bit   exp_clip;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int sat(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_w = 0;
    dc_x1 = '{0, 0};
    dc_y1 = '{0, 0};
    exp_valid = 1'b0;
    exp_l = 0;
    exp_r = 0;
    exp_clip = 1'b0;
  endtask

  // Expected output of one accepted sample; this also advances the weight and the filter history.
  task automatic model_accept(input int l, input int r, input int mx, output exp_t e);
    int tag;
    int tgt;
    int o[2];
    tag = m_w;
    tgt = (mx == 3) ? int'(WMAX) : mx;
    if (tgt > m_w) m_w++;
    else if (tgt < m_w) m_w--;
    o[0] = sat(l + floor_div((r - l) * tag, 8));
    o[1] = sat(r + floor_div((l - r) * tag, 8));
    e.clip = 1'b0;
`ifdef AUDIO_MIX_DCBLOCK_EN
    for (int ch = 0; ch < 2; ch++) begin
      int y;
      int ys;
      y  = o[ch] - dc_x1[ch] + dc_y1[ch] - floor_div(dc_y1[ch], 1024);
      ys = sat(y);
      if (ys != y) e.clip = 1'b1;
      dc_x1[ch] = o[ch];
      dc_y1[ch] = ys;
      o[ch] = ys;
    end
`endif
    e.l = o[0];
    e.r = o[1];
  endtask

  // One clock: drive the inputs, let the model predict, clock, then set the expected outputs for this cycle.
  task automatic tick(input bit ce, input int mx, input int l, input int r);
    exp_t e;
    bus.ce_smp = ce;
    bus.mix    = 2'(mx);
    bus.in_l   = DW'(l);
    bus.in_r   = DW'(r);
    if (ce) begin
      model_accept(l, r, mx, e);
      e.due = cyc + LAT;
      exp_q.push_back(e);
    end
    @(posedge clk_sys);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_valid = 1'b1;
      exp_l = e.l;
      exp_r = e.r;
      exp_clip = e.clip;
    end else begin
      exp_valid = 1'b0;
      exp_clip = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ce_smp = 1'b0;
    bus.mix = 2'd0;
    bus.in_l = '0;
    bus.in_r = '0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  task automatic test_reset();
    int nvalid;
    do_reset();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_l !== '0 || bus.out_r !== '0 || bus.clip !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values valid=%b l=%0d r=%0d clip=%b want all 0", bus.out_valid, $signed(bus.out_l), $signed(bus.out_r), bus.clip);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 3, 1000 + i * 777, -3000 + i * 123);
    // Assert reset between edges while samples are in flight; outputs must clear without waiting for a clock.
    bus.ce_smp = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_l !== '0 || bus.out_r !== '0 || bus.clip !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async valid=%b l=%0d r=%0d clip=%b want all 0", bus.out_valid, $signed(bus.out_l), $signed(bus.out_r), bus.clip);
    end
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    cyc = 0;
    model_reset();
    nvalid = 0;
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      tick(i == 3, 0, 1234, -4321);
      if (bus.out_valid === 1'b1) nvalid++;
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL reset_recover cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r);
      end
    end
    tests_run++;
    if (nvalid != 1) begin
      tests_failed++;
      $display("FAIL reset_flush valid_count=%0d want 1", nvalid);
    end
  endtask

  task automatic test_passthrough();
    int nvalid;
    int vat;
    do_reset();
    nvalid = 0;
    vat = -1;
    for (int i = 0; i < LAT + 4; i++) begin
      tick(i == 0, 0, 1000, -1000);
      if (bus.out_valid === 1'b1) begin
        nvalid++;
        vat = i;
      end
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL passthrough cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r);
      end
    end
    tests_run++;
    if (nvalid != 1 || vat != LAT - 1) begin
      tests_failed++;
      $display("FAIL passthrough_latency count=%0d at=%0d want 1 at %0d", nvalid, vat, LAT - 1);
    end
`ifndef AUDIO_MIX_DCBLOCK_EN
    tests_run++;
    if (bus.out_l !== 16'sd1000 || bus.out_r !== -16'sd1000) begin
      tests_failed++;
      $display("FAIL passthrough_value l=%0d r=%0d want 1000 -1000", $signed(bus.out_l), $signed(bus.out_r));
    end
`endif
  endtask

  task automatic test_ramp();
    int got_l[$];
    int got_r[$];
    int ref_l[6];
    int ref_r[6];
    ref_l = '{800, 700, 600, 500, 400, 400};
    ref_r = '{0, 100, 200, 300, 400, 400};
    do_reset();
    for (int i = 0; i < 6 * 4 + LAT; i++) begin
      tick((i % 4 == 0) && (i < 24), 3, 800, 0);
      if (bus.out_valid === 1'b1) begin
        got_l.push_back(int'($signed(bus.out_l)));
        got_r.push_back(int'($signed(bus.out_r)));
      end
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL ramp cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r);
      end
    end
`ifndef AUDIO_MIX_DCBLOCK_EN
    tests_run++;
    if (got_l.size() != 6) begin
      tests_failed++;
      $display("FAIL ramp_count got %0d samples want 6", got_l.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests_run++;
        if (got_l[k] != ref_l[k] || got_r[k] != ref_r[k]) begin
          tests_failed++;
          $display("FAIL ramp_table k=%0d l=%0d r=%0d want %0d %0d", k, got_l[k], got_r[k], ref_l[k], ref_r[k]);
        end
      end
    end
`endif
  endtask

  task automatic test_rounding();
    int got_l[$];
    int got_r[$];
    do_reset();
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 4) tick(1'b1, 3, 0, 0);
      else if (i == 4) tick(1'b1, 3, 0, -1);
      else if (i == 5) tick(1'b1, 3, -32768, 32767);
      else tick(1'b0, 3, 0, 0);
      if (bus.out_valid === 1'b1) begin
        got_l.push_back(int'($signed(bus.out_l)));
        got_r.push_back(int'($signed(bus.out_r)));
      end
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL rounding cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r);
      end
    end
`ifndef AUDIO_MIX_DCBLOCK_EN
    tests_run++;
    if (got_l.size() != 6 || got_l[4] != -1 || got_r[4] != -1 || got_l[5] != -1 || got_r[5] != -1) begin
      tests_failed++;
      $display("FAIL rounding_mono count=%0d want 6 with last two pairs -1,-1", got_l.size());
    end
`endif
  endtask

  task automatic test_stream_change();
    int run;
    int best;
    int got_l[$];
    int ref_l[10];
    ref_l = '{800, 700, 600, 500, 400, 500, 600, 700, 800, 800};
    do_reset();
    run = 0;
    best = 0;
    for (int i = 0; i < 10 + LAT; i++) begin
      tick(i < 10, (i < 4) ? 3 : 0, 800, 0);
      if (bus.out_valid === 1'b1) begin
        run++;
        got_l.push_back(int'($signed(bus.out_l)));
      end else begin
        run = 0;
      end
      if (run > best) best = run;
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL stream_change cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r);
      end
    end
    tests_run++;
    if (best != 10) begin
      tests_failed++;
      $display("FAIL stream_back_to_back longest run=%0d want 10", best);
    end
`ifndef AUDIO_MIX_DCBLOCK_EN
    for (int k = 0; k < 10 && k < got_l.size(); k++) begin
      tests_run++;
      if (got_l[k] != ref_l[k]) begin
        tests_failed++;
        $display("FAIL stream_weights k=%0d l=%0d want %0d", k, got_l[k], ref_l[k]);
      end
    end
`endif
  endtask

  task automatic test_random();
    int mx;
    do_reset();
    mx = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mx = int'($urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, mx, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL random cyc=%0d valid=%b want %b l=%0d want %0d r=%0d want %0d clip=%b want %b", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, $signed(bus.out_r), exp_r, bus.clip, exp_clip);
      end
    end
  endtask

`ifdef AUDIO_MIX_DCBLOCK_EN
  task automatic test_dcblock();
    int prev;
    bit saw_step;
    do_reset();
    prev = SMAX;
    saw_step = 1'b0;
    for (int i = 0; i < 4001 + LAT; i++) begin
      if (i < 4000) tick(1'b1, 0, 16384, 16384);
      else tick(i == 4000, 0, -32768, -32768);
      tests_run++;
      if (bus.out_valid !== exp_valid || bus.out_l !== DW'(exp_l) || bus.out_r !== DW'(exp_r) || bus.clip !== exp_clip) begin
        tests_failed++;
        $display("FAIL dcblock cyc=%0d valid=%b want %b l=%0d want %0d clip=%b want %b", cyc, bus.out_valid, exp_valid, $signed(bus.out_l), exp_l, bus.clip, exp_clip);
      end
      if (bus.out_valid === 1'b1 && i < 4000 + LAT - 1) begin
        tests_run++;
        if (int'($signed(bus.out_l)) > prev || $signed(bus.out_l) < 0) begin
          tests_failed++;
          $display("FAIL dcblock_monotonic cyc=%0d l=%0d prev %0d", cyc, $signed(bus.out_l), prev);
        end
        prev = int'($signed(bus.out_l));
      end
      if (bus.out_valid === 1'b1 && i == 4000 + LAT - 1) begin
        saw_step = 1'b1;
        tests_run++;
        if (bus.out_l !== 16'sh8000 || bus.clip !== 1'b1) begin
          tests_failed++;
          $display("FAIL dcblock_step l=%0d clip=%b want -32768 1", $signed(bus.out_l), bus.clip);
        end
      end
    end
    tests_run++;
    if (!saw_step) begin
      tests_failed++;
      $display("FAIL dcblock_step_missing no valid on the step sample");
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.ce_smp = 1'b0;
    bus.mix = 2'd0;
    bus.in_l = '0;
    bus.in_r = '0;
    model_reset();
    test_reset();
    test_passthrough();
    test_ramp();
    test_rounding();
    test_stream_change();
    test_random();
`ifdef AUDIO_MIX_DCBLOCK_EN
    test_dcblock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
